sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering data between blocks that share one clock domain. It succeeds the dual-clock FIFO for same-clock paths and adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, selectable first-word-fall-through (FWFT) or registered-read mode, synchronous flush, and sticky overflow/underflow error flags. No clock-domain crossing logic; all flags derive from one registered occupancy counter.

---
 rtl/sync_fifo.sv | 139 +++++++++++++
 tb/tb_sync_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, FWFT or registered read port, synchronous flush and sticky error flags.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 1,
  localparam int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;

  // Flags are pure decodes of the registered count, so they never glitch on the enables.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A flush masks both ports, so nothing is stored and no error is flagged that cycle.
  assign wr_accept = wr_en && !full  && !clear;
  assign rd_accept = rd_en && !empty && !clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (clear) begin
        rdata_d = '0;
      end else if (rd_accept) begin
        rdata_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign data_out = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench driving an FWFT and a registered-read sync_fifo with shared stimulus
// and checking both against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] f_data, r_data;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic       r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic [4:0] f_count, r_count;

  logic [7:0] expQ[$];
  int         mCount = 0;
  logic       mOvf = 1'b0;
  logic       mUnf = 1'b0;
  logic [7:0] mRdata = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1)) dutFwft (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_data), .full(f_full), .empty(f_empty), .almost_full(f_afull),
    .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(0)) dutReg (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(r_data), .full(r_full), .empty(r_empty), .almost_full(r_afull),
    .almost_empty(r_aempty), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
  );

  // Single comparison point: every check is counted here and mismatches reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [10:0] modelStatus();
    logic [4:0] c;
    c = 5'(mCount);
    return {c, (mCount == 16), (mCount == 0), (mCount >= 12), (mCount <= 4), mOvf, mUnf};
  endfunction

  // Compares both DUTs against the model; FWFT shows the queue head, registered mode the last read.
  task automatic checkAll(input string tag);
    logic [7:0] head;
    head = (expQ.size() != 0) ? expQ[0] : 8'h00;
    checkOutput({tag, "/fwft_status"}, 32'({f_count, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf}), 32'(modelStatus()));
    checkOutput({tag, "/reg_status"},  32'({r_count, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf}), 32'(modelStatus()));
    checkOutput({tag, "/fwft_data"}, 32'(f_data), 32'(head));
    checkOutput({tag, "/reg_data"},  32'(r_data), 32'(mRdata));
  endtask

  // Drives one cycle of stimulus, advances the model with pre-edge occupancy, then checks.
  task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd, input logic clr, input string tag);
    logic wa, ra;
    @(negedge clk);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    clear   = clr;
    wa = wr && (mCount != 16) && !clr;
    ra = rd && (mCount != 0) && !clr;
    if (clr) begin
      expQ.delete();
      mOvf   = 1'b0;
      mUnf   = 1'b0;
      mRdata = 8'h00;
    end else begin
      if (wr && mCount == 16) mOvf = 1'b1;
      if (rd && mCount == 0) mUnf = 1'b1;
      if (ra) mRdata = expQ.pop_front();
      if (wa) expQ.push_back(din);
    end
    mCount = expQ.size();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] d;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, "overflow");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");

    // Collision at empty: write wins, read flagged; 0x5C then visible on the FWFT port.
    applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0, "empty_both");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "read_5c");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "read_empty_hold");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "hold_after_empty");

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "clear1");
    d = 8'h20;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, d, 1'b0, 1'b0, "prefill8");
      d++;
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, d, 1'b1, 1'b0, "steady8");
      d++;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, d, 1'b0, 1'b0, "refill");
      d++;
    end
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, "full_both");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "down_to5");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, "clear_with_write");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "after_clear");

    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h90 + 8'(i), (i > 2), 1'b0, "traffic");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    expQ.delete();
    mCount = 0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
    mRdata = 8'h00;
    #1;
    checkAll("async_reset");
    idle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, "post_reset_wr");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "post_reset_rd");
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
